// File: rtl/packet_arbiter.sv
// Weighted round-robin grant arbiter for four packet sources, weights programmed over SPI.
// Define STARVE_WDOG_EN to add per-source starvation watchdogs that override the rotation.
module packet_arbiter #(
    parameter logic [7:0]  ADDR_WEIGHT_FIRST = 8'h20,
    parameter logic [15:0] STARVE_LIMIT      = 16'd1024
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       DONE,
    input  logic [7:0] SPI_ADDRESS,
    input  logic [7:0] SPI_DATA,
    input  logic       RISING_SS,
    output logic [3:0] GRANT,
    output logic       GRANT_VALID,
    output logic [1:0] GRANT_IDX,
    output logic [3:0] STARVE
);

    typedef enum logic {SCAN, BUSY} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [3:0][7:0] weight_q, weight_d;
    logic [3:0][7:0] credit_q, credit_d;
    logic [3:0]      grant_q, grant_d;
    logic            valid_q, valid_d;
    logic [1:0]      idx_q, idx_d;

    logic [3:0]      starveVec;
    logic [3:0]      starveElig;
    logic            starveHit;
    logic [1:0]      starveIdx;
    logic [1:0]      ptrNext;
    logic [7:0]      wOffset;
    logic            eligible;

`ifdef STARVE_WDOG_EN
    logic [3:0][15:0] cnt_q, cnt_d;
    logic [3:0]       starve_q, starve_d;

    // Starve flag is registered alongside its counter so it always equals (cnt_q == STARVE_LIMIT).
    always_comb begin
        cnt_d    = cnt_q;
        starve_d = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            if (!REQ[n] || grant_q[n]) begin
                cnt_d[n] = 16'd0;
            end else if (weight_q[n] != 8'd0 && cnt_q[n] != STARVE_LIMIT) begin
                cnt_d[n] = cnt_q[n] + 16'd1;
            end
            starve_d[n] = (cnt_d[n] == STARVE_LIMIT);
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            cnt_q    <= '0;
            starve_q <= 4'b0000;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign starveVec = starve_q;
    assign STARVE    = starve_q;
`else
    assign starveVec = 4'b0000;
    assign STARVE    = 4'b0000;
`endif

    always_comb begin
        starveElig = starveVec & REQ;
        starveIdx  = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (weight_q[n] == 8'd0) begin
                starveElig[n] = 1'b0;
            end
            if (starveElig[n]) begin
                starveIdx = 2'(n);
            end
        end
        starveHit = |starveElig;
    end

    assign ptrNext  = ptr_q + 2'd1;
    assign wOffset  = SPI_ADDRESS - ADDR_WEIGHT_FIRST;
    assign eligible = REQ[ptr_q] && (weight_q[ptr_q] != 8'd0) && (credit_q[ptr_q] != 8'd0);

    // Reloads read weight_q, so a weight write landing in the same cycle only takes effect next time.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        weight_d = weight_q;
        credit_d = credit_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        idx_d    = idx_q;

        unique case (state_q)
            SCAN: begin
                if (starveHit) begin
                    ptr_d   = starveIdx;
                    grant_d = 4'b0001 << starveIdx;
                    valid_d = 1'b1;
                    idx_d   = starveIdx;
                    state_d = BUSY;
                    if (credit_q[starveIdx] != 8'd0) begin
                        credit_d[starveIdx] = credit_q[starveIdx] - 8'd1;
                    end
                end else if (eligible) begin
                    grant_d         = 4'b0001 << ptr_q;
                    valid_d         = 1'b1;
                    idx_d           = ptr_q;
                    credit_d[ptr_q] = credit_q[ptr_q] - 8'd1;
                    state_d         = BUSY;
                end else begin
                    ptr_d             = ptrNext;
                    credit_d[ptrNext] = weight_q[ptrNext];
                end
            end
            BUSY: begin
                if (DONE) begin
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                    idx_d   = 2'd0;
                    state_d = SCAN;
                    if (credit_q[ptr_q] == 8'd0) begin
                        ptr_d             = ptrNext;
                        credit_d[ptrNext] = weight_q[ptrNext];
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        if (RISING_SS && wOffset < 8'd4) begin
            weight_d[wOffset[1:0]] = SPI_DATA;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= SCAN;
            ptr_q    <= 2'd0;
            weight_q <= {4{8'd1}};
            credit_q <= {4{8'd1}};
            grant_q  <= 4'b0000;
            valid_q  <= 1'b0;
            idx_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            weight_q <= weight_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
        end
    end

    assign GRANT       = grant_q;
    assign GRANT_VALID = valid_q;
    assign GRANT_IDX   = idx_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed self-checking bench for packet_arbiter; expected grant orders are worked out by hand.
// The long all-requesting rotations run only without STARVE_WDOG_EN, where no watchdog can reorder them.
module tb_packet_arbiter;

    logic       SYS_CLK = 1'b0;
    logic       RST;
    logic [3:0] REQ;
    logic       DONE;
    logic [7:0] SPI_ADDRESS;
    logic [7:0] SPI_DATA;
    logic       RISING_SS;
    logic [3:0] GRANT;
    logic       GRANT_VALID;
    logic [1:0] GRANT_IDX;
    logic [3:0] STARVE;

    int testsRun = 0;
    int failCount = 0;

    packet_arbiter #(
        .ADDR_WEIGHT_FIRST(8'h20),
        .STARVE_LIMIT     (16'd16)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .REQ        (REQ),
        .DONE       (DONE),
        .SPI_ADDRESS(SPI_ADDRESS),
        .SPI_DATA   (SPI_DATA),
        .RISING_SS  (RISING_SS),
        .GRANT      (GRANT),
        .GRANT_VALID(GRANT_VALID),
        .GRANT_IDX  (GRANT_IDX),
        .STARVE     (STARVE)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic applyReset(input logic [3:0] req);
        RST         = 1'b0;
        DONE        = 1'b0;
        RISING_SS   = 1'b0;
        SPI_ADDRESS = 8'h00;
        SPI_DATA    = 8'h00;
        REQ         = req;
        repeat (2) tick();
        checkOutput("rstGrant", 32'(GRANT), 32'h0);
        checkOutput("rstValid", 32'(GRANT_VALID), 32'h0);
        checkOutput("rstIdx", 32'(GRANT_IDX), 32'h0);
        checkOutput("rstStarve", 32'(STARVE), 32'h0);
        RST = 1'b1;
    endtask

    task automatic spiWrite(input logic [7:0] addr, input logic [7:0] data);
        SPI_ADDRESS = addr;
        SPI_DATA    = data;
        RISING_SS   = 1'b1;
        tick();
        RISING_SS   = 1'b0;
    endtask

    task automatic waitGrant(output int cycles);
        cycles = 0;
        while (!GRANT_VALID && cycles < 20) begin
            tick();
            cycles++;
        end
        if (!GRANT_VALID) begin
            checkOutput("grantTimeout", 32'(GRANT_VALID), 32'h1);
        end
    endtask

    task automatic expectGrant(input string tag, input int expIdx);
        int cyc;
        waitGrant(cyc);
        checkOutput({tag, "Idx"}, 32'(GRANT_IDX), 32'(expIdx));
        checkOutput({tag, "Onehot"}, 32'(GRANT), 32'(1) << expIdx);
    endtask

    task automatic finishGrant(input int hold);
        repeat (hold) tick();
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        checkOutput("gapValid", 32'(GRANT_VALID), 32'h0);
    endtask

    task automatic applyStimulus();
        int cyc;
        int seqWrr[7] = '{0, 0, 0, 1, 3, 3, 0};
        int seqReload[9] = '{2, 3, 0, 1, 1, 1, 1, 1, 2};

`ifndef STARVE_WDOG_EN
        // Default weights; out-of-range SPI writes must not disable any source.
        applyReset(4'b0000);
        spiWrite(8'h24, 8'h00);
        spiWrite(8'h1F, 8'h00);
        repeat (2) tick();
        REQ = 4'b1111;
        waitGrant(cyc);
        checkOutput("rrFirstLatency", 32'(cyc), 32'd1);
        checkOutput("rrFirstIdx", 32'(GRANT_IDX), 32'd0);
        finishGrant(10);
        for (int i = 1; i < 5; i++) begin
            expectGrant($sformatf("rr%0d", i), i % 4);
            finishGrant(10);
        end

        // Weights {3,1,0,2}; twelve idle cycles leave PTR at 0 with every credit reloaded.
        applyReset(4'b0000);
        spiWrite(8'h20, 8'd3);
        spiWrite(8'h21, 8'd1);
        spiWrite(8'h22, 8'd0);
        spiWrite(8'h23, 8'd2);
        repeat (8) tick();
        REQ = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            expectGrant($sformatf("wrr%0d", i), seqWrr[i]);
            finishGrant(2);
        end

        // Weight write to the granted source keeps the grant and applies at its next reload.
        applyReset(4'b1111);
        expectGrant("wwSrc0", 0);
        finishGrant(2);
        expectGrant("wwSrc1", 1);
        spiWrite(8'h21, 8'h05);
        checkOutput("wwHeldGrant", 32'(GRANT), 32'h2);
        checkOutput("wwHeldValid", 32'(GRANT_VALID), 32'h1);
        finishGrant(3);
        for (int i = 0; i < 9; i++) begin
            expectGrant($sformatf("reload%0d", i), seqReload[i]);
            finishGrant(1);
        end
`endif

        // Lone requester at source 2: three scan steps from PTR 0, then REQ drop is ignored.
        applyReset(4'b0100);
        waitGrant(cyc);
        checkOutput("lateLatency", 32'(cyc), 32'd3);
        checkOutput("lateGrant", 32'(GRANT), 32'h4);
        REQ = 4'b0000;
        repeat (5) tick();
        checkOutput("busyHoldGrant", 32'(GRANT), 32'h4);
        checkOutput("busyHoldIdx", 32'(GRANT_IDX), 32'd2);
        finishGrant(0);

        // Asynchronous reset in the middle of a grant.
        applyReset(4'b1111);
        expectGrant("arSrc0", 0);
        finishGrant(1);
        expectGrant("arSrc1", 1);
        repeat (3) tick();
        #3;
        RST = 1'b0;
        #1;
        checkOutput("asyncGrant", 32'(GRANT), 32'h0);
        checkOutput("asyncValid", 32'(GRANT_VALID), 32'h0);
        checkOutput("asyncIdx", 32'(GRANT_IDX), 32'h0);
        REQ = 4'b1100;
        tick();
        tick();
        RST = 1'b1;
        waitGrant(cyc);
        checkOutput("postRstLatency", 32'(cyc), 32'd3);
        checkOutput("postRstIdx", 32'(GRANT_IDX), 32'd2);
        finishGrant(0);

        // Source 0 holds a long grant with plenty of credit while source 1 waits.
        applyReset(4'b0000);
        spiWrite(8'h20, 8'hFF);
        repeat (3) tick();
        REQ = 4'b0011;
        expectGrant("wdogFirst", 0);
        repeat (40) tick();
`ifdef STARVE_WDOG_EN
        checkOutput("wdogStarve", 32'(STARVE), 32'h2);
`else
        checkOutput("wdogStarve", 32'(STARVE), 32'h0);
`endif
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        checkOutput("wdogGap", 32'(GRANT_VALID), 32'h0);
        tick();
`ifdef STARVE_WDOG_EN
        checkOutput("wdogOverride", 32'(GRANT), 32'h2);
        repeat (2) tick();
        checkOutput("wdogCleared", 32'(STARVE), 32'h0);
`else
        checkOutput("wdogOverride", 32'(GRANT), 32'h1);
`endif
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
